// File: rtl/gpio_7seg_scan.sv
// gpio_7seg_scan
//   Scans DIGITS active-low seven-segment codes onto one shared GPIO segment
//   bus with one-hot digit selects. Codes are double-buffered (staging ->
//   display) and the display copy only changes at a frame boundary, so a
//   frame is never torn. Each digit slot lasts DIV clocks. The first BLANK
//   clocks of every slot drive all outputs inactive to suppress ghosting.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   en         in   scan enable; counters hold and outputs go inactive when low
//   seg_in     in   7*DIGITS segment codes, digit k at [7k+6:7k], 0 = lit
//   load       in   one-cycle strobe capturing seg_in into staging
//   seg_out    out  shared segment bus (polarity set by SEG_INV)
//   sel        out  one-hot digit select (polarity set by SEL_ACTIVE_HIGH)
//   frame_done out  one-cycle pulse after the last slot of each frame

// Per-digit staging/display pair. Both reset to all ones (segments off).
module gpio_7seg_digit (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       load,
    input  logic       commit,
    input  logic       pending,
    input  logic [6:0] code,
    output logic [6:0] disp
);
    logic [6:0] stg;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            stg  <= 7'h7F;
            disp <= 7'h7F;
        end else begin
            if (load)
                stg <= code;
            // A load on the boundary cycle bypasses staging so the new code
            // is shown in the very next frame.
            if (commit) begin
                if (load)
                    disp <= code;
                else if (pending)
                    disp <= stg;
            end
        end
    end
endmodule

module gpio_7seg_scan #(
    parameter int DIGITS          = 2,
    parameter int DIV             = 50000,
    parameter int BLANK           = 500,
    parameter int SEG_INV         = 1,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  en,
    input  logic [7*DIGITS-1:0]   seg_in,
    input  logic                  load,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = (SEG_INV != 0) ? 7'h00 : 7'h7F;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          pending;

    logic [DIGITS-1:0][6:0] code_in;
    logic [DIGITS-1:0][6:0] display;
    logic [DIGITS-1:0]      hot;

    logic       slot_end;
    logic       idx_last;
    logic       boundary;
    logic       in_blank;
    logic       visible;
    logic [6:0] code_cur;
    logic [6:0] seg_lit;

    assign code_in  = seg_in;
    assign slot_end = (cnt == CW'(DIV - 1));
    assign idx_last = (idx == IW'(DIGITS - 1));
    assign boundary = en && slot_end && idx_last;

    // With BLANK=0 the comparison would be trivially false; keep it out.
    generate
        if (BLANK == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CW'(BLANK));
        end
    endgenerate

    assign visible  = en && !in_blank;
    assign code_cur = display[idx];
    assign seg_lit  = (SEG_INV != 0) ? ~code_cur : code_cur;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dig
            assign hot[k] = (idx == IW'(k));

            gpio_7seg_digit u_digit (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .load     (load),
                .commit   (boundary),
                .pending  (pending),
                .code     (code_in[k]),
                .disp     (display[k])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            sel        <= SEL_OFF;
            seg_out    <= SEG_OFF;
        end else begin
            frame_done <= boundary;

            // Boundary clears pending even when a load lands on it: the
            // bypass path has already moved that code into display.
            if (boundary)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;

            if (en) begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= idx_last ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Outputs follow the counter by one cycle; hot is strictly
            // one-hot since idx never leaves 0..DIGITS-1.
            if (visible) begin
                sel     <= (SEL_ACTIVE_HIGH != 0) ? hot : ~hot;
                seg_out <= seg_lit;
            end else begin
                sel     <= SEL_OFF;
                seg_out <= SEG_OFF;
            end
        end
    end
endmodule

// File: tb/tb_gpio_7seg_scan.sv
module tb_gpio_7seg_scan;
    localparam int DIGITS = 2;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b0;
    logic        en       = 1'b0;
    logic        load     = 1'b0;
    logic [13:0] seg_in   = '0;
    logic [6:0]  seg_out;
    logic [1:0]  sel;
    logic        frame_done;

    always #5 CLOCK_50 = ~CLOCK_50;

    gpio_7seg_scan #(
        .DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK),
        .SEG_INV(1), .SEL_ACTIVE_HIGH(1)
    ) u_dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .en         (en),
        .seg_in     (seg_in),
        .load       (load),
        .seg_out    (seg_out),
        .sel        (sel),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // scoreboard entry: {frame_done, sel, seg_out}
    logic [9:0] sb[$];

    // reference model state
    int          m_cnt;
    int          m_idx;
    logic        m_pend;
    logic [13:0] m_stg;
    logic [13:0] m_disp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_pend = 1'b0;
        m_stg  = '1;
        m_disp = '1;
    endtask

    // Predict next-cycle outputs from model state + current inputs, push,
    // advance the model, clock, then pop and compare.
    task automatic step();
        logic [9:0] e;
        logic [9:0] o;
        logic       bnd;
        logic [6:0] code;
        if (!reset) begin
            model_reset();
            e = '0;
        end else begin
            bnd = en && (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
            if (!en || m_cnt < BLANK) begin
                e = {bnd, 2'b00, 7'h00};
            end else begin
                code = m_disp[m_idx*7 +: 7];
                e = {bnd, 2'(1 << m_idx), ~code};
            end
            if (bnd) begin
                if (load) m_disp = seg_in;
                else if (m_pend) m_disp = m_stg;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) m_stg = seg_in;
            if (en) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        o = {frame_done, sel, seg_out};
        e = sb.pop_front();
        chk("cycle", 32'(o), 32'(e));
    endtask

    task automatic align();
        int n;
        n = 0;
        while (!(m_cnt == 0 && m_idx == 0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("align_tmo", 0, 1);
    endtask

    // One full aligned frame; checks digit contents and a single frame_done.
    task automatic frame_check(input logic [6:0] exp0, input logic [6:0] exp1);
        int nfd;
        nfd = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            if (sel == 2'b01) chk("dig0", 32'(seg_out), 32'(exp0));
            if (sel == 2'b10) chk("dig1", 32'(seg_out), 32'(exp1));
            if (frame_done) nfd++;
        end
        chk("fd_per_frame", nfd, 1);
    endtask

    initial begin
        int n;
        int period;
        bit dropped;
        model_reset();

        // reset state
        repeat (3) step();
        chk("rst_seg", 32'(seg_out), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_pend", 32'(u_dut.pending), 0);

        reset = 1'b1;
        repeat (2) step();
        en = 1'b1;

        // idle scan, blank display
        align();
        frame_check(7'h00, 7'h00);
        frame_check(7'h00, 7'h00);

        // mid-frame load shows only from the next frame
        repeat (5) step();
        seg_in = {7'h79, 7'h40};
        load = 1'b1;
        step();
        load = 1'b0;
        seg_in = '0;
        align();
        frame_check(7'h3F, 7'h06);

        // two loads in one frame: last wins
        repeat (3) step();
        seg_in = 14'h0000;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (4) step();
        seg_in = {7'h24, 7'h30};
        load = 1'b1;
        step();
        load = 1'b0;
        align();
        frame_check(7'h4F, 7'h5B);

        // load exactly on the boundary cycle
        n = 0;
        while (!(m_cnt == DIV - 1 && m_idx == DIGITS - 1) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("bnd_tmo", 0, 1);
        seg_in = {7'h19, 7'h02};
        load = 1'b1;
        step();
        load = 1'b0;
        seg_in = '0;
        chk("pend_after_bnd", 32'(u_dut.pending), 0);
        frame_check(7'h7D, 7'h66);

        // en dropped 5 cycles during digit-1 visible time
        n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("fd_tmo", 0, 1);
        period  = 0;
        dropped = 0;
        n = 0;
        do begin
            step();
            period++;
            n++;
            if (!dropped && m_idx == 1 && m_cnt == 4) begin
                dropped = 1;
                en = 1'b0;
                step();
                period++;
                chk("en0_sel", 32'(sel), 0);
                chk("en0_seg", 32'(seg_out), 0);
                repeat (4) step();
                period += 4;
                en = 1'b1;
            end
        end while (!frame_done && n < 60);
        if (n >= 60) chk("period_tmo", 0, 1);
        chk("stretch_period", period, 2 * DIV + 5);

        // reset mid digit-0 slot with pending load
        align();
        repeat (4) step();
        seg_in = 14'h0000;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("pre_rst_pend", 32'(u_dut.pending), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_sel", 32'(sel), 0);
        chk("async_seg", 32'(seg_out), 0);
        chk("async_pend", 32'(u_dut.pending), 0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        chk("restart_dig0", 32'(sel), 32'h1);
        align();
        frame_check(7'h00, 7'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gpio_7seg_scan.md
Name: gpio_7seg_scan

Overview:
- Downstream stage of the board counter: drives an external multiplexed seven-segment display through GPIO.
- Takes per-digit segment codes in the active-low form the on-board bcdto7seg decoders produce.
- Double-buffers them so a frame is never torn, and time-multiplexes one shared segment bus across DIGITS one-hot digit selects.
- Inserts a blanking interval at each digit switch so the display does not ghost.

Parameters:
- DIGITS, 2, number of scanned digits (>=1)
- DIV, 50000, clocks per digit slot (>=2); 1 ms per slot at 50 MHz
- BLANK, 500, clocks at the start of each slot with all outputs inactive (0 <= BLANK < DIV)
- SEG_INV, 1, 1 means seg_out = ~code (active-high external segments); 0 means pass-through
- SEL_ACTIVE_HIGH, 1, polarity of sel; inactive level is the complement

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  scan enable
- seg_in  input  7*DIGITS  segment codes; digit k at bits [7k+6:7k]; active-low (0 = lit)
- load  input  1  single-cycle strobe; captures seg_in into the staging register
- seg_out  output  7  shared segment bus to GPIO
- sel  output  DIGITS  one-hot digit select to GPIO
- frame_done  output  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0, pending=0.
  - staging and display registers all ones (all segments off).
  - seg_out = off level (7'h00 when SEG_INV=1, else 7'h7F).
  - sel = all inactive; frame_done = 0.
- Slot counter:
  - cnt counts 0..DIV-1 when en=1, then wraps to 0 and advances idx.
  - idx counts 0..DIGITS-1, then wraps to 0.
- Frame boundary: the cycle with en=1, cnt==DIV-1 and idx==DIGITS-1.
  - frame_done=1 on the following cycle only.
  - display <= staging if pending=1; pending <= 0.
- Load capture:
  - load=1 writes seg_in into staging on any cycle, regardless of en, and sets pending.
  - A later load before the boundary overwrites staging (last write wins).
  - load coincident with a frame boundary: display takes seg_in directly (bypass), staging also gets seg_in, pending ends 0.
- Outputs are registered from the current (cnt, idx, display): one cycle latency behind the counter.
  - cnt < BLANK: sel all inactive, seg_out off.
  - Otherwise: sel bit idx active, others inactive; seg_out = display digit idx, inverted per SEG_INV.
  - No cycle ever has two sel bits active.
- en=0:
  - cnt and idx hold; next cycle sel is all inactive and seg_out is off; no frame_done.
  - Re-asserting en resumes from the held cnt/idx, with the blank/visible decision re-evaluated from cnt.
- BLANK=0: no blanking; digits switch directly on consecutive cycles.
- DIGITS=1: sel is a single bit, and every slot end is a frame boundary.
- Reset mid-frame: everything returns immediately to reset values, pending is dropped, and the scan restarts at digit 0 after release.
- Widths: cnt is $clog2(DIV) bits; idx is max(1,$clog2(DIGITS)) bits. Neither counter ever reaches an out-of-range value.

Test Plan (DIGITS=2, DIV=8, BLANK=2, SEG_INV=1, SEL_ACTIVE_HIGH=1 unless noted):
- Reset, then en=1, no load -> seg_out=7'h00 always. sel pattern repeating every 16 cycles: 00 x2, 01 x6, 00 x2, 10 x6. frame_done pulses once per 16 cycles.
- load with seg_in={7'h79,7'h40} (digit1="1", digit0="0") mid-frame -> outputs unchanged until the boundary. Next frame: seg_out=7'h3F while sel=01 and 7'h06 while sel=10.
- Two loads in one frame (first 14'h0000, then {7'h24,7'h30}) -> next frame shows only the second value: seg_out 7'h4F then 7'h5B.
- load asserted exactly on a boundary cycle -> the new value is visible in the immediately following frame's digit-0 slot; pending is 0 afterwards.
- en dropped for 5 cycles during digit-1 visible time -> sel=00 and seg_out=00 from the next cycle. After en returns, digit 1 completes its remaining visible cycles; the frame period is stretched by exactly 5 cycles.
- reset asserted mid digit-0 slot with pending=1 -> sel/seg_out go inactive asynchronously. After release, display stays blank (staging dropped) and the scan begins at digit 0.
